// File: rtl/ram_bus_ctrl.sv
// CPU-side RAM bus sequencer: issues SRC + WRM/RDM instruction cycles on the shared 4-bit bus.
// Optional SRC address cache enabled by defining RAM_BUS_SRC_CACHE_EN.
module ram_bus_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_chip,
  input  logic [1:0] req_reg,
  input  logic [3:0] req_char,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_rdata,
  inout  wire  [3:0] data,
  output logic       sync,
  output logic       cmd_n
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_SRC,
    ST_IO
  } state_e;

  localparam logic [3:0] SRC_OPR = 4'h2;
  localparam logic [3:0] IO_OPR  = 4'hE;
  localparam logic [3:0] WRM_OPA = 4'h0;
  localparam logic [3:0] RDM_OPA = 4'h9;

  state_e     state_q, state_d;
  logic [2:0] cycle_q, cycle_d;
  logic       write_q, write_d;
  logic       chip_q, chip_d;
  logic [1:0] reg_q, reg_d;
  logic [3:0] char_q, char_d;
  logic [3:0] wdata_q, wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_rdata_q, rsp_rdata_d;

  logic       src_hit;
  logic       bus_en;
  logic [3:0] bus_val;
  logic       cmd_n_o;

`ifdef RAM_BUS_SRC_CACHE_EN
  logic       last_valid_q, last_valid_d;
  logic       last_chip_q, last_chip_d;
  logic [1:0] last_reg_q, last_reg_d;
  logic [3:0] last_char_q, last_char_d;

  // RAM chips keep their SRC address between accesses, so an identical
  // address needs no new SRC cycle.
  assign src_hit = last_valid_q && (last_chip_q == chip_q) &&
                   (last_reg_q == reg_q) && (last_char_q == char_q);
`else
  assign src_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q + 3'd1;
    write_d     = write_q;
    chip_d      = chip_q;
    reg_d       = reg_q;
    char_d      = char_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_BUS_SRC_CACHE_EN
    last_valid_d = last_valid_q;
    last_chip_d  = last_chip_q;
    last_reg_d   = last_reg_q;
    last_char_d  = last_char_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          chip_d  = req_chip;
          reg_d   = req_reg;
          char_d  = req_char;
          wdata_d = req_wdata;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (cycle_q == 3'd7) begin
          state_d = src_hit ? ST_IO : ST_SRC;
        end
      end
      ST_SRC: begin
        if (cycle_q == 3'd7) begin
          state_d = ST_IO;
`ifdef RAM_BUS_SRC_CACHE_EN
          last_valid_d = 1'b1;
          last_chip_d  = chip_q;
          last_reg_d   = reg_q;
          last_char_d  = char_q;
`endif
        end
      end
      ST_IO: begin
        if (cycle_q == 3'd6) begin
          rsp_valid_d = 1'b1;
          if (!write_q) begin
            rsp_rdata_d = data;
          end
        end
        if (cycle_q == 3'd7) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus drive slots and command strobe, decoded from registered state only.
  always_comb begin
    bus_en  = 1'b0;
    bus_val = '0;
    cmd_n_o = 1'b1;
    unique case (state_q)
      ST_SRC: begin
        unique case (cycle_q)
          3'd3: begin
            bus_en  = 1'b1;
            bus_val = SRC_OPR;
          end
          3'd6: begin
            bus_en  = 1'b1;
            bus_val = {1'b0, chip_q, reg_q};
            cmd_n_o = 1'b0;
          end
          3'd7: begin
            bus_en  = 1'b1;
            bus_val = char_q;
          end
          default: ;
        endcase
      end
      ST_IO: begin
        unique case (cycle_q)
          3'd3: begin
            bus_en  = 1'b1;
            bus_val = IO_OPR;
          end
          3'd4: begin
            bus_en  = 1'b1;
            bus_val = write_q ? WRM_OPA : RDM_OPA;
            cmd_n_o = 1'b0;
          end
          3'd6: begin
            bus_en  = write_q;
            bus_val = wdata_q;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cycle_q     <= '0;
      write_q     <= 1'b0;
      chip_q      <= 1'b0;
      reg_q       <= '0;
      char_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      write_q     <= write_d;
      chip_q      <= chip_d;
      reg_q       <= reg_d;
      char_q      <= char_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef RAM_BUS_SRC_CACHE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      last_valid_q <= 1'b0;
      last_chip_q  <= 1'b0;
      last_reg_q   <= '0;
      last_char_q  <= '0;
    end else begin
      last_valid_q <= last_valid_d;
      last_chip_q  <= last_chip_d;
      last_reg_q   <= last_reg_d;
      last_char_q  <= last_char_d;
    end
  end
`endif

  assign data      = bus_en ? bus_val : 4'bzzzz;
  assign cmd_n     = cmd_n_o;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sync      = (cycle_q == 3'd7);

endmodule
